// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: pairs 1-cycle-latency fetch responses with their tags,
// feeds the decode slot and absorbs one response in a skid entry while stalled.
module if_id_buffer #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc_plus_4,
    input  logic        fetch_interrupt,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        flush,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus_4,
    output logic        id_interrupt,
    output logic        id_valid,
    output logic        skid_full,
    output logic        overflow,
    output logic [15:0] stall_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        tag_valid_q, tag_valid_d;
    logic [31:0] tag_pc4_q, tag_pc4_d;
    logic        tag_int_q, tag_int_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        skid_int_q, skid_int_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_int_q, id_int_d;
    logic        id_valid_q, id_valid_d;
    logic        overflow_q, overflow_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        state_d      = state_q;
        tag_valid_d  = fetch_req & ~flush;
        tag_pc4_d    = fetch_pc_plus_4;
        tag_int_d    = fetch_interrupt;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        skid_int_d   = skid_int_q;
        id_instr_d   = id_instr_q;
        id_pc4_d     = id_pc4_q;
        id_int_d     = id_int_q;
        id_valid_d   = id_valid_q;
        overflow_d   = overflow_q;
        stall_cnt_d  = stall_cnt_q;

        if (stall && !flush && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;

        if (flush) begin
            state_d    = EMPTY;
            id_valid_d = 1'b0;
            id_instr_d = NOP_INSTR;
            id_pc4_d   = 32'h0;
            id_int_d   = 1'b0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (!stall) begin
                        id_valid_d = tag_valid_q;
                        id_instr_d = tag_valid_q ? mem_rdata : NOP_INSTR;
                        id_pc4_d   = tag_valid_q ? tag_pc4_q : 32'h0;
                        id_int_d   = tag_valid_q & tag_int_q;
                    end else if (tag_valid_q) begin
                        skid_instr_d = mem_rdata;
                        skid_pc4_d   = tag_pc4_q;
                        skid_int_d   = tag_int_q;
                        state_d      = FULL;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        // skid is older than any response arriving now
                        id_valid_d = 1'b1;
                        id_instr_d = skid_instr_q;
                        id_pc4_d   = skid_pc4_q;
                        id_int_d   = skid_int_q;
                        if (tag_valid_q) begin
                            skid_instr_d = mem_rdata;
                            skid_pc4_d   = tag_pc4_q;
                            skid_int_d   = tag_int_q;
                        end else begin
                            state_d = EMPTY;
                        end
                    end else if (tag_valid_q) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            tag_valid_q  <= 1'b0;
            tag_pc4_q    <= 32'h0;
            tag_int_q    <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc4_q   <= 32'h0;
            skid_int_q   <= 1'b0;
            id_instr_q   <= NOP_INSTR;
            id_pc4_q     <= 32'h0;
            id_int_q     <= 1'b0;
            id_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            stall_cnt_q  <= 16'h0;
        end else begin
            state_q      <= state_d;
            tag_valid_q  <= tag_valid_d;
            tag_pc4_q    <= tag_pc4_d;
            tag_int_q    <= tag_int_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_int_q   <= skid_int_d;
            id_instr_q   <= id_instr_d;
            id_pc4_q     <= id_pc4_d;
            id_int_q     <= id_int_d;
            id_valid_q   <= id_valid_d;
            overflow_q   <= overflow_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign id_instr     = id_instr_q;
    assign id_pc_plus_4 = id_pc4_q;
    assign id_interrupt = id_int_q;
    assign id_valid     = id_valid_q;
    assign skid_full    = (state_q == FULL);
    assign overflow     = overflow_q;
    assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: streaming, stall, overflow,
// flush-over-stall, interrupt tagging and mid-stream reset.
module tb_if_id_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req;
    logic [31:0] fetch_pc_plus_4;
    logic        fetch_interrupt;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus_4;
    logic        id_interrupt;
    logic        id_valid;
    logic        skid_full;
    logic        overflow;
    logic [15:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    if_id_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_req       (fetch_req),
        .fetch_pc_plus_4 (fetch_pc_plus_4),
        .fetch_interrupt (fetch_interrupt),
        .mem_rdata       (mem_rdata),
        .stall           (stall),
        .flush           (flush),
        .id_instr        (id_instr),
        .id_pc_plus_4    (id_pc_plus_4),
        .id_interrupt    (id_interrupt),
        .id_valid        (id_valid),
        .skid_full       (skid_full),
        .overflow        (overflow),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic req, input logic [31:0] pc4,
                         input logic intr, input logic [31:0] rd,
                         input logic st, input logic fl);
        fetch_req       = req;
        fetch_pc_plus_4 = pc4;
        fetch_interrupt = intr;
        mem_rdata       = rd;
        stall           = st;
        flush           = fl;
    endtask

    task automatic chk_slot(input string tag, input logic v,
                            input logic [31:0] ins, input logic [31:0] pc4,
                            input logic intr, input logic sk);
        chk({tag, "_valid"}, {31'h0, id_valid}, {31'h0, v});
        chk({tag, "_instr"}, id_instr, ins);
        chk({tag, "_pc4"}, id_pc_plus_4, pc4);
        chk({tag, "_int"}, {31'h0, id_interrupt}, {31'h0, intr});
        chk({tag, "_skid"}, {31'h0, skid_full}, {31'h0, sk});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk_slot("rst", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rst_ovf", {31'h0, overflow}, 32'h0);
        chk("rst_cnt", {16'h0, stall_count}, 32'h0);

        // streaming A, B, C
        drive(1'b1, 32'd4, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("lat1_valid", {31'h0, id_valid}, 32'h0);
        drive(1'b1, 32'd8, 1'b0, 32'hAAAA_0001, 1'b0, 1'b0);
        tick();
        chk_slot("strA", 1'b1, 32'hAAAA_0001, 32'd4, 1'b0, 1'b0);
        drive(1'b1, 32'd12, 1'b0, 32'hBBBB_0002, 1'b0, 1'b0);
        tick();
        chk_slot("strB", 1'b1, 32'hBBBB_0002, 32'd8, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'hCCCC_0003, 1'b0, 1'b0);
        tick();
        chk_slot("strC", 1'b1, 32'hCCCC_0003, 32'd12, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        tick();
        chk_slot("strIdle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // single stall while B arrives
        drive(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h14, 1'b0, 32'hA2A2_0000, 1'b0, 1'b0);
        tick();
        chk_slot("stA", 1'b1, 32'hA2A2_0000, 32'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h18, 1'b0, 32'hB2B2_0000, 1'b1, 1'b0);
        tick();
        chk_slot("stHold", 1'b1, 32'hA2A2_0000, 32'h10, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'hC2C2_0000, 1'b0, 1'b0);
        tick();
        chk_slot("stB", 1'b1, 32'hB2B2_0000, 32'h14, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
        tick();
        chk_slot("stC", 1'b1, 32'hC2C2_0000, 32'h18, 1'b0, 1'b0);
        chk("stCnt", {16'h0, stall_count}, 32'd1);
        chk("stOvf", {31'h0, overflow}, 32'h0);
        tick();
        chk_slot("stIdle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // overflow: 3 stalled cycles, response each cycle
        do_reset();
        drive(1'b1, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h24, 1'b0, 32'hD0D0_0000, 1'b1, 1'b0);
        tick();
        chk("ov1_skid", {31'h0, skid_full}, 32'h1);
        chk("ov1_ovf", {31'h0, overflow}, 32'h0);
        drive(1'b1, 32'h28, 1'b0, 32'hD1D1_0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'hD2D2_0000, 1'b1, 1'b0);
        tick();
        chk_slot("ov3", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk("ov3_ovf", {31'h0, overflow}, 32'h1);
        chk("ov3_cnt", {16'h0, stall_count}, 32'd3);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_slot("ovDrain", 1'b1, 32'hD0D0_0000, 32'h20, 1'b0, 1'b0);
        tick();
        chk_slot("ovIdle", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("ovSticky", {31'h0, overflow}, 32'h1);

        // flush over stall with skid full
        drive(1'b1, 32'h2C, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h30, 1'b0, 32'hE9E9_0000, 1'b0, 1'b0);
        tick();
        chk_slot("flPre", 1'b1, 32'hE9E9_0000, 32'h2C, 1'b0, 1'b0);
        drive(1'b1, 32'h34, 1'b0, 32'hE0E0_0000, 1'b1, 1'b0);
        tick();
        chk("flFull", {31'h0, skid_full}, 32'h1);
        chk("flCnt0", {16'h0, stall_count}, 32'd4);
        drive(1'b1, 32'h38, 1'b0, 32'hE1E1_0000, 1'b1, 1'b1);
        tick();
        chk_slot("flush", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("flCnt", {16'h0, stall_count}, 32'd4);
        drive(1'b0, 32'h0, 1'b0, 32'hE2E2_0000, 1'b0, 1'b0);
        tick();
        chk_slot("flAfter", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        chk_slot("flNoSkid", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        // interrupt tagging
        drive(1'b1, 32'h100, 1'b1, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h104, 1'b0, 32'hF0F0_0000, 1'b0, 1'b0);
        tick();
        chk_slot("irq", 1'b1, 32'hF0F0_0000, 32'h100, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 1'b0, 32'hF1F1_0000, 1'b0, 1'b0);
        tick();
        chk_slot("irqNext", 1'b1, 32'hF1F1_0000, 32'h104, 1'b0, 1'b0);

        // reset mid-stream: skid full, stall_count 5, overflow set
        do_reset();
        drive(1'b1, 32'h1FC, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h200, 1'b0, 32'h9999_0000, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h204, 1'b0, 32'h6060_0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h6161_0000, 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        chk_slot("rsPre", 1'b1, 32'h9999_0000, 32'h1FC, 1'b0, 1'b1);
        chk("rsPreCnt", {16'h0, stall_count}, 32'd5);
        chk("rsPreOvf", {31'h0, overflow}, 32'h1);
        rst = 1'b1;
        drive(1'b1, 32'h208, 1'b1, 32'h6262_0000, 1'b1, 1'b1);
        tick();
        chk_slot("rsMid", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("rsMidOvf", {31'h0, overflow}, 32'h0);
        chk("rsMidCnt", {16'h0, stall_count}, 32'h0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h6363_0000, 1'b0, 1'b0);
        tick();
        chk_slot("rsAfter", 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
